// File: rtl/adder_pkg.sv
// Shared constants and sizing helpers for the segmented pipelined adder.
package adder_pkg;

  localparam int WA_DEFAULT   = 57;
  localparam int WB_DEFAULT   = 16;
  localparam int NSEG_DEFAULT = 3;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  function automatic int seg_width(input int width, input int nseg);
    return (width + nseg - 1) / nseg;
  endfunction

  // Width actually owned by segment k; 0 once the segments run past the result.
  function automatic int seg_bits(input int width, input int segw, input int k);
    int lo;
    lo = k * segw;
    if (lo >= width) return 0;
    if (width - lo < segw) return width - lo;
    return segw;
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline stage: adds its segment of the operands plus the incoming carry,
// registers the partially-complete result, remaining operand bits and carry-out.
module adder_seg_stage #(
  parameter int W  = 58,
  parameter int LO = 0,
  parameter int SW = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_acc,
  input  logic [W-1:0] up_b,
  input  logic         up_carry,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_acc,
  output logic [W-1:0] dn_b,
  output logic         dn_carry
);

  logic         valid_reg;
  logic [W-1:0] acc_reg;
  logic [W-1:0] b_reg;
  logic         carry_reg;
  logic [W-1:0] acc_next;
  logic         carry_next;

  assign up_ready = !valid_reg || dn_ready;

  generate
    if (SW > 0) begin : g_add
      logic [SW:0] seg_sum;

      assign seg_sum = {1'b0, up_acc[LO +: SW]} + {1'b0, up_b[LO +: SW]}
                     + {{SW{1'b0}}, up_carry};

      // acc carries finished low bits below LO and untouched A bits above.
      always_comb begin
        acc_next             = up_acc;
        acc_next[LO +: SW]   = seg_sum[SW-1:0];
      end

      assign carry_next = seg_sum[SW];
    end else begin : g_pass
      logic unused_carry;

      assign unused_carry = up_carry;
      assign acc_next     = up_acc;
      assign carry_next   = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      acc_reg   <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
    end else if (up_ready) begin
      valid_reg <= up_valid;
      if (up_valid) begin
        acc_reg   <= acc_next;
        b_reg     <= up_b;
        carry_reg <= carry_next;
      end
    end
  end

  assign dn_valid = valid_reg;
  assign dn_acc   = acc_reg;
  assign dn_b     = b_reg;
  assign dn_carry = carry_reg;

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined WA+1-bit adder of unsigned A and zero/sign-extended B, split into
// NSEG carry-chain segments with one register stage each and valid/ready flow.
module seg_pipe_adder
  import adder_pkg::*;
#(
  parameter int WA   = WA_DEFAULT,
  parameter int WB   = WB_DEFAULT,
  parameter int NSEG = NSEG_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  input  logic          b_sext,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA:0]   sum
);

  localparam int W    = WA + 1;
  localparam int SEGW = seg_width(W, NSEG);

  logic [W-1:0] acc_s [NSEG+1];
  logic [W-1:0] b_s   [NSEG+1];
  logic [NSEG:0] carry_s;
  logic [NSEG:0] valid_s;
  logic [NSEG:0] ready_s;

  assign acc_s[0]      = {1'b0, a};
  assign b_s[0]        = {{(W-WB){(b_sext == EXT_SIGN) & b[WB-1]}}, b};
  assign carry_s[0]    = 1'b0;
  assign valid_s[0]    = in_valid;
  assign ready_s[NSEG] = out_ready;
  assign in_ready      = ready_s[0];

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_stage
      localparam int LO = gi * SEGW;
      localparam int SW = seg_bits(W, SEGW, gi);

      adder_seg_stage #(
        .W  (W),
        .LO (LO),
        .SW (SW)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (valid_s[gi]),
        .up_ready (ready_s[gi]),
        .up_acc   (acc_s[gi]),
        .up_b     (b_s[gi]),
        .up_carry (carry_s[gi]),
        .dn_valid (valid_s[gi+1]),
        .dn_ready (ready_s[gi+1]),
        .dn_acc   (acc_s[gi+1]),
        .dn_b     (b_s[gi+1]),
        .dn_carry (carry_s[gi+1])
      );
    end
  endgenerate

  // The final carry-out is the wrapped-off bit; remaining operand bits are spent.
  logic unused_tail;
  assign unused_tail = ^{b_s[NSEG], carry_s[NSEG]};

  assign sum       = acc_s[NSEG];
  assign out_valid = valid_s[NSEG];

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed bench for seg_pipe_adder: vector table, streaming, backpressure,
// mid-stream reset and NSEG=1/58 latency sweep against a bench-side model.
module tb_seg_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, b_sext, out_valid, out_ready;
  logic [56:0] a;
  logic [15:0] b;
  logic [57:0] sum;

  logic        s_in_valid, s_b_sext, s_out_ready;
  logic [56:0] s_a;
  logic [15:0] s_b;
  logic        s_in_ready1, s_out_valid1, s_in_ready58, s_out_valid58;
  logic [57:0] s_sum1, s_sum58;

  seg_pipe_adder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_sext(b_sext), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum)
  );

  seg_pipe_adder #(.NSEG(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready1),
    .a(s_a), .b(s_b), .b_sext(s_b_sext), .out_valid(s_out_valid1),
    .out_ready(s_out_ready), .sum(s_sum1)
  );

  seg_pipe_adder #(.NSEG(58)) u_n58 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready58),
    .a(s_a), .b(s_b), .b_sext(s_b_sext), .out_valid(s_out_valid58),
    .out_ready(s_out_ready), .sum(s_sum58)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [56:0] a;
    logic [15:0] b;
    logic        sx;
    logic [57:0] exp;
  } vec_t;

  vec_t        vecs [9];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          n_emit = 0;
  string       tag = "init";
  logic [57:0] exp_q [$];
  int          acc_q [$];
  logic        last_in_ready, last_out_valid;
  logic [57:0] last_sum;

  function automatic logic [57:0] model(input logic [56:0] av, input logic [15:0] bv,
                                        input logic sx);
    logic [57:0] bx;
    bx = sx ? {{42{bv[15]}}, bv} : {42'd0, bv};
    return {1'b0, av} + bx;
  endfunction

  task automatic check(input string name, input logic [57:0] act, input logic [57:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // One cycle on the main DUT: drive, observe handshakes, advance to next negedge.
  task automatic step(input logic iv, input logic [56:0] av, input logic [15:0] bv,
                      input logic sx, input logic ordy, input logic chk_lat,
                      input logic have_exp, input logic [57:0] exp_v);
    logic [57:0] e;
    int          t;
    in_valid  = iv;
    a         = av;
    b         = bv;
    b_sext    = sx;
    out_ready = ordy;
    #1;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    last_sum       = sum;
    if (out_valid && out_ready) begin
      n_emit++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s/unexpected_result: got %h expected none", tag, sum);
      end else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        check("sum", sum, e);
        if (chk_lat) check("latency", 58'(cyc - t), 58'd3);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(have_exp ? exp_v : model(av, bv, sx));
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int bound, input logic chk_lat);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, chk_lat, 1'b0, '0);
      k++;
    end
    check("drain_left", 58'(exp_q.size()), 58'd0);
  endtask

  function automatic logic [56:0] rand_a();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[56:0];
  endfunction

  initial begin
    logic [63:0] rb;
    int          emit0;
    int          seen1, seen58;
    int          sv [2];

    vecs[0] = '{57'h1FF_FFFF_FFFF_FFFF, 16'h0001, 1'b0, 58'h200_0000_0000_0000};
    vecs[1] = '{57'h100,               16'hFFFF, 1'b1, 58'h0FF};
    vecs[2] = '{57'h100,               16'hFFFF, 1'b0, 58'h100FF};
    vecs[3] = '{57'h0,                 16'h0000, 1'b0, 58'h0};
    vecs[4] = '{57'h0,                 16'h8000, 1'b1, 58'h3FF_FFFF_FFFF_8000};
    vecs[5] = '{57'h1FF_FFFF_FFFF_FFFF, 16'hFFFF, 1'b1, 58'h1FF_FFFF_FFFF_FFFE};
    vecs[6] = '{57'h0F_FFFF,           16'h0001, 1'b0, 58'h10_0000};
    vecs[7] = '{57'hFF_FFFF_FFFF,      16'h0001, 1'b0, 58'h100_0000_0000};
    vecs[8] = '{57'h1FF_FFFF_FFFF_FFFF, 16'h0001, 1'b1, 58'h200_0000_0000_0000};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; b_sext = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_b_sext = 1'b0; s_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tag = "reset";
    check("out_valid", 58'(out_valid), 58'd0);
    check("sum", sum, 58'd0);
    check("in_ready", 58'(in_ready), 58'd1);
    check("n1_out_valid", 58'(s_out_valid1), 58'd0);
    check("n58_out_valid", 58'(s_out_valid58), 58'd0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("vec%0d", i);
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].sx, 1'b1, 1'b1, 1'b1, vecs[i].exp);
      drain(10, 1'b1);
      $display("[TB] vec%0d a=%h b=%h sext=%0d exp=%h", i, vecs[i].a, vecs[i].b,
               vecs[i].sx, vecs[i].exp);
    end

    tag = "stream";
    emit0 = n_emit;
    for (int i = 0; i < 10; i++) begin
      rb = {$urandom(), $urandom()};
      step(1'b1, rand_a(), rb[15:0], rb[20], 1'b1, 1'b1, 1'b0, '0);
      check("in_ready", 58'(last_in_ready), 58'd1);
    end
    drain(10, 1'b1);
    check("count", 58'(n_emit - emit0), 58'd10);
    $display("[TB] stream: %0d results", n_emit - emit0);

    tag = "backpressure";
    emit0 = n_emit;
    for (int i = 0; i < 6; i++) begin
      rb = {$urandom(), $urandom()};
      step(1'b1, rand_a(), rb[15:0], rb[33], 1'b0, 1'b0, 1'b0, '0);
      check("in_ready", 58'(last_in_ready), (i < 3) ? 58'd1 : 58'd0);
      if (i >= 3) begin
        check("stall_valid", 58'(last_out_valid), 58'd1);
        check("stall_sum", last_sum, exp_q[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rb = {$urandom(), $urandom()};
      step(1'b1, rand_a(), rb[15:0], rb[40], 1'b1, 1'b0, 1'b0, '0);
      check("full_accept", 58'(last_in_ready), 58'd1);
    end
    drain(12, 1'b0);
    check("count", 58'(n_emit - emit0), 58'd7);
    $display("[TB] backpressure: %0d results", n_emit - emit0);

    tag = "reset_mid";
    emit0 = n_emit;
    step(1'b1, 57'h123_4567, 16'h89AB, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 57'h1FF_FFFF_FFFF_FFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("out_valid", 58'(out_valid), 58'd0);
    check("sum", sum, 58'd0);
    check("in_ready", 58'(in_ready), 58'd1);
    @(negedge clk);
    cyc++;
    repeat (6) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("flushed", 58'(n_emit - emit0), 58'd0);
    step(1'b1, vecs[2].a, vecs[2].b, vecs[2].sx, 1'b1, 1'b1, 1'b1, vecs[2].exp);
    drain(10, 1'b1);
    $display("[TB] reset_mid: %0d results after flush", n_emit - emit0);

    sv[0] = 0;
    sv[1] = 4;
    for (int v = 0; v < 2; v++) begin
      tag = $sformatf("sweep_vec%0d", sv[v]);
      s_a = vecs[sv[v]].a; s_b = vecs[sv[v]].b; s_b_sext = vecs[sv[v]].sx;
      s_in_valid = 1'b1; s_out_ready = 1'b1;
      #1;
      check("n1_in_ready", 58'(s_in_ready1), 58'd1);
      check("n58_in_ready", 58'(s_in_ready58), 58'd1);
      @(negedge clk);
      s_in_valid = 1'b0;
      seen1 = -1;
      seen58 = -1;
      for (int n = 1; n <= 70; n++) begin
        #1;
        if (s_out_valid1) begin
          if (seen1 < 0) begin
            seen1 = n;
            check("n1_sum", s_sum1, vecs[sv[v]].exp);
          end else check("n1_dup", 58'(n), 58'(seen1));
        end
        if (s_out_valid58) begin
          if (seen58 < 0) begin
            seen58 = n;
            check("n58_sum", s_sum58, vecs[sv[v]].exp);
          end else check("n58_dup", 58'(n), 58'(seen58));
        end
        @(negedge clk);
      end
      check("n1_latency", 58'(seen1), 58'd1);
      check("n58_latency", 58'(seen58), 58'd58);
      $display("[TB] sweep vec%0d latency n1=%0d n58=%0d", sv[v], seen1, seen58);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
